// File: rtl/host_cfg_sequencer.sv
// host_cfg_sequencer: turns a stream of host configuration commands into
// registered host_controller strobes and ex_bus transfers for the PE fabric.
module host_cfg_sequencer #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int INST_W  = 48,
  parameter int SPM_W   = 24,
  parameter int A_W     = 10,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int PE_HOLD = 9,
  localparam int CMD_W  = 4 + ROWS + COLS + INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              run,
  output logic              init_spm,
  output logic [ROWS-1:0]   init_row,
  output logic              init_lsu,
  output logic [COLS-1:0]   init_pe,
  output logic [INST_W-1:0] inst,
  output logic              ex_wen,
  output logic              ex_ren,
  output logic [A_W-1:0]    ex_addr,
  output logic [DATA_W-1:0] ex_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PE_W  = $clog2(PE_HOLD + 1);
  localparam int REM_W = (CNT_W > PE_W) ? CNT_W : PE_W;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_CFG_PE  = 4'd1;
  localparam logic [3:0] OP_CFG_LSU = 4'd2;
  localparam logic [3:0] OP_CFG_SPM = 4'd3;
  localparam logic [3:0] OP_EX_BASE = 4'd4;
  localparam logic [3:0] OP_EX_WR   = 4'd5;
  localparam logic [3:0] OP_EX_RD   = 4'd6;
  localparam logic [3:0] OP_RUN     = 4'd7;
  localparam logic [3:0] OP_WAIT    = 4'd8;
  localparam logic [3:0] OP_END     = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_next;
  logic [REM_W-1:0]   remaining;
  logic [A_W-1:0]     ptr;
  logic               accept;
  logic               start_go;

  logic [3:0]         op;
  logic [ROWS-1:0]    row_mask;
  logic [COLS-1:0]    col_mask;
  logic [INST_W-1:0]  arg;

  assign op       = cmd_data[CMD_W-1 -: 4];
  assign row_mask = cmd_data[INST_W+COLS +: ROWS];
  assign col_mask = cmd_data[INST_W +: COLS];
  assign arg      = cmd_data[INST_W-1:0];

  assign cmd_ready = (state == S_RUN) && (remaining == '0);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  // abort suppresses any same-cycle handshake or start
  assign accept    = cmd_valid && cmd_ready && !abort;
  assign start_go  = start && !abort && (state != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_go) state_next = S_RUN;
        S_RUN:   if (accept && op == OP_END) state_next = S_DONE;
        S_DONE:  if (start_go) state_next = S_RUN;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Pulses are loaded on acceptance and held while remaining counts down;
  // with nothing accepted and nothing left to hold they fall back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      run       <= 1'b0;
      init_spm  <= 1'b0;
      init_row  <= '0;
      init_lsu  <= 1'b0;
      init_pe   <= '0;
      ex_wen    <= 1'b0;
      ex_ren    <= 1'b0;
      inst      <= '0;
      ex_addr   <= '0;
      ex_data   <= '0;
      ptr       <= '0;
      remaining <= '0;
    end else if (abort) begin
      run       <= 1'b0;
      init_spm  <= 1'b0;
      init_row  <= '0;
      init_lsu  <= 1'b0;
      init_pe   <= '0;
      ex_wen    <= 1'b0;
      ex_ren    <= 1'b0;
      remaining <= '0;
    end else if (accept) begin
      run       <= 1'b0;
      init_spm  <= 1'b0;
      init_row  <= '0;
      init_lsu  <= 1'b0;
      init_pe   <= '0;
      ex_wen    <= 1'b0;
      ex_ren    <= 1'b0;
      remaining <= '0;
      case (op)
        OP_NOP: ;
        OP_CFG_PE: begin
          init_row  <= row_mask;
          init_pe   <= col_mask;
          inst      <= arg;
          remaining <= REM_W'(PE_HOLD - 1);
        end
        OP_CFG_LSU: begin
          init_row <= row_mask;
          init_lsu <= 1'b1;
          inst     <= arg;
        end
        OP_CFG_SPM: begin
          init_spm <= 1'b1;
          inst     <= INST_W'(arg[SPM_W-1:0]);
        end
        OP_EX_BASE: ptr <= arg[A_W-1:0];
        OP_EX_WR: begin
          ex_wen  <= 1'b1;
          ex_addr <= ptr;
          ex_data <= arg[DATA_W-1:0];
          ptr     <= ptr + A_W'(1);
        end
        OP_EX_RD: begin
          ex_ren  <= 1'b1;
          ex_addr <= ptr;
          ptr     <= ptr + A_W'(1);
        end
        OP_RUN:  run <= 1'b1;
        OP_WAIT: remaining <= REM_W'(arg[CNT_W-1:0]);
        default: ;
      endcase
    end else if (remaining != '0) begin
      remaining <= remaining - REM_W'(1);
    end else begin
      run      <= 1'b0;
      init_spm <= 1'b0;
      init_row <= '0;
      init_lsu <= 1'b0;
      init_pe  <= '0;
      ex_wen   <= 1'b0;
      ex_ren   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         err <= 1'b0;
    else if (accept && op > OP_END)  err <= 1'b1;
    else if (start_go)               err <= 1'b0;
  end

endmodule

// File: tb/tb_host_cfg_sequencer.sv
// tb_host_cfg_sequencer: scoreboard bench; each accepted command pushes its
// expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_host_cfg_sequencer;

  localparam int ROWS = 4, COLS = 4, INST_W = 48, SPM_W = 24, A_W = 10;
  localparam int DATA_W = 32, CNT_W = 16, PE_HOLD = 9;
  localparam int CMD_W = 4 + ROWS + COLS + INST_W;

  logic clk = 1'b0;
  logic rst, start, abort, cmd_valid, cmd_ready;
  logic [CMD_W-1:0] cmd_data;
  logic run, init_spm, init_lsu, ex_wen, ex_ren, busy, done, err;
  logic [ROWS-1:0] init_row;
  logic [COLS-1:0] init_pe;
  logic [INST_W-1:0] inst;
  logic [A_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_data;

  typedef struct packed {
    logic              run;
    logic              init_spm;
    logic [ROWS-1:0]   init_row;
    logic              init_lsu;
    logic [COLS-1:0]   init_pe;
    logic [INST_W-1:0] inst;
    logic              ex_wen;
    logic              ex_ren;
    logic [A_W-1:0]    ex_addr;
    logic [DATA_W-1:0] ex_data;
  } obs_t;

  obs_t exp_q[$];
  obs_t last_rec;
  obs_t mon_o, mon_e;
  logic [A_W-1:0] m_ptr;
  int run_q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  host_cfg_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .INST_W(INST_W), .SPM_W(SPM_W), .A_W(A_W),
    .DATA_W(DATA_W), .CNT_W(CNT_W), .PE_HOLD(PE_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .run(run), .init_spm(init_spm), .init_row(init_row), .init_lsu(init_lsu),
    .init_pe(init_pe), .inst(inst), .ex_wen(ex_wen), .ex_ren(ex_ren),
    .ex_addr(ex_addr), .ex_data(ex_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle; an empty queue means pulses low, fields held.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_o = {run, init_spm, init_row, init_lsu, init_pe, inst, ex_wen, ex_ren, ex_addr, ex_data};
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
      end else begin
        mon_e = last_rec;
        mon_e.run = 1'b0; mon_e.init_spm = 1'b0; mon_e.init_row = '0;
        mon_e.init_lsu = 1'b0; mon_e.init_pe = '0; mon_e.ex_wen = 1'b0; mon_e.ex_ren = 1'b0;
      end
      checks++;
      if (mon_o !== mon_e) begin
        errors++;
        $display("[TB] FAIL outputs cyc %0d: got %h expected %h", cyc, mon_o, mon_e);
      end
      if (run === 1'b1) run_q.push_back(cyc);
    end
  end

  task automatic model_reset;
    exp_q.delete();
    last_rec = '0;
    m_ptr = '0;
  endtask

  task automatic push_expected(input logic [3:0] op, input logic [ROWS-1:0] rm,
                               input logic [COLS-1:0] cm, input logic [INST_W-1:0] arg);
    obs_t r;
    int d;
    d = 1;
    r = last_rec;
    r.run = 1'b0; r.init_spm = 1'b0; r.init_row = '0; r.init_lsu = 1'b0;
    r.init_pe = '0; r.ex_wen = 1'b0; r.ex_ren = 1'b0;
    case (op)
      4'd1: begin r.init_row = rm; r.init_pe = cm; r.inst = arg; d = PE_HOLD; end
      4'd2: begin r.init_row = rm; r.init_lsu = 1'b1; r.inst = arg; end
      4'd3: begin r.init_spm = 1'b1; r.inst = {24'h0, arg[23:0]}; end
      4'd4: m_ptr = arg[A_W-1:0];
      4'd5: begin r.ex_wen = 1'b1; r.ex_addr = m_ptr; r.ex_data = arg[DATA_W-1:0]; m_ptr = m_ptr + 1'b1; end
      4'd6: begin r.ex_ren = 1'b1; r.ex_addr = m_ptr; m_ptr = m_ptr + 1'b1; end
      4'd7: r.run = 1'b1;
      4'd8: d = int'(arg[CNT_W-1:0]) + 1;
      default: ;
    endcase
    for (int i = 0; i < d; i++) exp_q.push_back(r);
    last_rec = r;
  endtask

  // Called at posedge+1; returns at posedge+1 of the command's first output cycle.
  task automatic send_cmd(input logic [3:0] op, input logic [ROWS-1:0] rm,
                          input logic [COLS-1:0] cm, input logic [INST_W-1:0] arg);
    int n;
    n = 0;
    cmd_data = {op, rm, cm, arg};
    cmd_valid = 1'b1;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handshake op %0d: cmd_ready=%b expected 1", op, cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      push_expected(op, rm, cm, arg);
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    checks++;
    if ({run, init_spm, init_row, init_lsu, init_pe, inst, ex_wen, ex_ren, ex_addr, ex_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {run, init_spm, init_row, init_lsu, init_pe, inst, ex_wen, ex_ren, ex_addr, ex_data});
    end
    checks++;
    if ({busy, done, err, cmd_ready} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_status: busy/done/err/ready=%b expected 0000", {busy, done, err, cmd_ready});
    end
    mon_en = 1'b1;
    do_start();
    checks++;
    if ({busy, done, cmd_ready} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL start_status: busy/done/ready=%b expected 101", {busy, done, cmd_ready});
    end
    send_cmd(4'd6, '0, '0, '0);
    checks++;
    if (ex_ren !== 1'b1 || ex_addr !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_ptr: ex_ren=%b ex_addr=%h expected 1/000", ex_ren, ex_addr);
    end
  endtask

  task automatic test_cfg_pe;
    send_cmd(4'd1, 4'b1000, 4'b1000, 48'h004708078d9f);
    checks++;
    if (init_row !== 4'b1000 || init_pe !== 4'b1000 || inst !== 48'h004708078d9f) begin
      errors++;
      $display("[TB] FAIL cfg_pe_fields: row=%b pe=%b inst=%h expected 1000/1000/004708078d9f", init_row, init_pe, inst);
    end
    for (int i = 0; i < PE_HOLD; i++) begin
      checks++;
      if (cmd_ready !== (i == PE_HOLD - 1)) begin
        errors++;
        $display("[TB] FAIL cfg_pe_ready hold cycle %0d: got %b expected %b", i + 1, cmd_ready, (i == PE_HOLD - 1));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (init_row !== 4'b0000 || init_pe !== 4'b0000 || inst !== 48'h004708078d9f) begin
      errors++;
      $display("[TB] FAIL cfg_pe_release: row=%b pe=%b inst=%h expected 0000/0000/held", init_row, init_pe, inst);
    end
    send_cmd(4'd3, '0, '0, 48'habcdef123456);
    checks++;
    if (init_spm !== 1'b1 || inst !== 48'h000000123456) begin
      errors++;
      $display("[TB] FAIL cfg_spm: init_spm=%b inst=%h expected 1/000000123456", init_spm, inst);
    end
  endtask

  task automatic test_ex_burst;
    send_cmd(4'd4, '0, '0, 48'h0);
    for (int k = 1; k <= 100; k++) send_cmd(4'd5, '0, '0, 48'(k));
    checks++;
    if (ex_wen !== 1'b1 || ex_addr !== 10'd99 || ex_data !== 32'd100) begin
      errors++;
      $display("[TB] FAIL ex_burst_last: wen=%b addr=%0d data=%0d expected 1/99/100", ex_wen, ex_addr, ex_data);
    end
  endtask

  task automatic test_ptr_wrap;
    logic [A_W-1:0] want [3];
    want[0] = 10'h3FE; want[1] = 10'h3FF; want[2] = 10'h000;
    send_cmd(4'd4, '0, '0, 48'h3FE);
    for (int k = 0; k < 3; k++) begin
      send_cmd(4'd5, '0, '0, 48'(32'hA0 + k));
      checks++;
      if (ex_addr !== want[k]) begin
        errors++;
        $display("[TB] FAIL ptr_wrap write %0d: addr=%h expected %h", k, ex_addr, want[k]);
      end
    end
  endtask

  task automatic test_run_wait_end;
    run_q.delete();
    send_cmd(4'd7, '0, '0, '0);
    send_cmd(4'd8, '0, '0, 48'd3);
    send_cmd(4'd7, '0, '0, '0);
    send_cmd(4'd9, '0, '0, '0);
    checks++;
    if ({done, busy, cmd_ready} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL end_status: done/busy/ready=%b expected 100", {done, busy, cmd_ready});
    end
    checks++;
    if (run_q.size() != 2 || run_q[1] - run_q[0] != 5) begin
      errors++;
      $display("[TB] FAIL run_spacing: pulses=%0d spacing=%0d expected 2/5", run_q.size(),
               (run_q.size() == 2) ? run_q[1] - run_q[0] : -1);
    end
    cmd_data = {4'd7, 4'h0, 4'h0, 48'h0};
    cmd_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
    checks++;
    if ({done, busy, run} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL done_ignores_cmd: done/busy/run=%b expected 100", {done, busy, run});
    end
    do_start();
    checks++;
    if ({done, busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL restart_from_done: done/busy=%b expected 01", {done, busy});
    end
  endtask

  task automatic test_lsu_gap;
    send_cmd(4'd0, '0, '0, '0);
    send_cmd(4'd2, 4'b0100, 4'b1111, 48'h111111111111);
    send_cmd(4'd2, 4'b0100, 4'b1111, 48'h222222222222);
    checks++;
    if (init_lsu !== 1'b1 || init_row !== 4'b0100 || init_pe !== 4'b0000 || inst !== 48'h222222222222) begin
      errors++;
      $display("[TB] FAIL lsu_second: lsu=%b row=%b pe=%b inst=%h expected 1/0100/0000/222222222222",
               init_lsu, init_row, init_pe, inst);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (init_lsu !== 1'b0 || inst !== 48'h222222222222 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lsu_gap: lsu=%b inst=%h busy=%b expected 0/222222222222/1", init_lsu, inst, busy);
    end
    @(posedge clk); #1;
    send_cmd(4'd2, 4'b0100, 4'b1111, 48'h333333333333);
    checks++;
    if (init_lsu !== 1'b1 || inst !== 48'h333333333333) begin
      errors++;
      $display("[TB] FAIL lsu_third: lsu=%b inst=%h expected 1/333333333333", init_lsu, inst);
    end
  endtask

  task automatic test_abort_err;
    send_cmd(4'hC, '0, '0, 48'h1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_op_err: err=%b expected 1", err);
    end
    send_cmd(4'd4, '0, '0, 48'h55);
    send_cmd(4'd5, '0, '0, 48'hAA);
    send_cmd(4'd1, 4'b0011, 4'b0101, 48'h0000cafe0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    checks++;
    if (init_row !== 4'b0000 || init_pe !== 4'b0000 || inst !== 48'h0000cafe0001) begin
      errors++;
      $display("[TB] FAIL abort_outputs: row=%b pe=%b inst=%h expected 0000/0000/0000cafe0001", init_row, init_pe, inst);
    end
    checks++;
    if ({busy, cmd_ready, done, err} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL abort_status: busy/ready/done/err=%b expected 0001", {busy, cmd_ready, done, err});
    end
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    checks++;
    if ({busy, err} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL abort_beats_start: busy/err=%b expected 01", {busy, err});
    end
    do_start();
    checks++;
    if ({busy, err} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL start_clears_err: busy/err=%b expected 10", {busy, err});
    end
    send_cmd(4'd5, '0, '0, 48'h77);
    checks++;
    if (ex_addr !== 10'h056 || ex_data !== 32'h77) begin
      errors++;
      $display("[TB] FAIL ptr_kept_on_abort: addr=%h data=%h expected 056/00000077", ex_addr, ex_data);
    end
  endtask

  task automatic test_rst_midcmd;
    send_cmd(4'd1, 4'b1111, 4'b1111, 48'h123456789abc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if ({run, init_spm, init_row, init_lsu, init_pe, inst, ex_wen, ex_ren, ex_addr, ex_data,
         busy, done, err, cmd_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_midcmd: row=%b pe=%b inst=%h busy=%b ready=%b expected all 0",
               init_row, init_pe, inst, busy, cmd_ready);
    end
    do_start();
    send_cmd(4'd6, '0, '0, '0);
    checks++;
    if (ex_addr !== 10'h000) begin
      errors++;
      $display("[TB] FAIL rst_ptr: addr=%h expected 000", ex_addr);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_cfg_pe();
    test_ex_burst();
    test_ptr_wrap();
    test_run_wait_end();
    test_lsu_gap();
    test_abort_err();
    test_rst_midcmd();
    repeat (3) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
